uns_acc: RTL and testbench

- Unsigned 6-bit accumulator with a selectable 3-bit addend.
- Each rising clock edge adds i_data1, i_data2, their sum, or nothing to the running total.
- Exposes the registered total and the carry-out of the most recent addition.
- Used as a small arithmetic building block in datapath exercises. Single clock domain.

---
 rtl/uns_acc.sv | 44 ++++
 tb/tb_uns_acc.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/uns_acc.sv
// Unsigned 6-bit accumulator with a selectable 3-bit addend.
// Ports: clk, i_rst_n (async low), i_data1/i_data2 (3b), i_sel (2b) -> o_data (6b), o_carry.
module uns_acc (
    input  logic       clk,
    input  logic       i_rst_n,
    input  logic [2:0] i_data1,
    input  logic [2:0] i_data2,
    input  logic [1:0] i_sel,
    output logic [5:0] o_data,
    output logic       o_carry
);

    logic [6:0] addend;
    logic [6:0] sum;
    logic       hold;

    always_comb begin
        addend = '0;
        hold   = 1'b0;
        unique case (i_sel)
            2'b00: addend = {4'b0, i_data1};
            2'b01: addend = {4'b0, i_data2};
            2'b10: addend = {4'b0, i_data1} + {4'b0, i_data2};
            2'b11: hold   = 1'b1;
            default: hold = 1'b1;
        endcase
    end

    // Bit 6 of the 7-bit sum is the carry out of the 6-bit total.
    assign sum = {1'b0, o_data} + addend;

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_data  <= '0;
            o_carry <= 1'b0;
        end else if (hold) begin
            o_carry <= 1'b0;
        end else begin
            o_data  <= sum[5:0];
            o_carry <= sum[6];
        end
    end

endmodule

// File: tb/tb_uns_acc.sv
// Scoreboard bench for uns_acc.
// Stimulus pushes expected values; a negedge monitor pops and compares.
module tb_uns_acc;

    logic       clk;
    logic       i_rst_n;
    logic [2:0] i_data1;
    logic [2:0] i_data2;
    logic [1:0] i_sel;
    logic [5:0] o_data;
    logic       o_carry;

    typedef struct {
        string      name;
        logic [5:0] d;
        logic       c;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    logic [5:0] md;
    logic       mc;

    uns_acc dut (
        .clk     (clk),
        .i_rst_n (i_rst_n),
        .i_data1 (i_data1),
        .i_data2 (i_data2),
        .i_sel   (i_sel),
        .o_data  (o_data),
        .o_carry (o_carry)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        while (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            checks++;
            if (o_data !== e.d || o_carry !== e.c) begin
                errors++;
                $display("FAIL %s: got o_data=%0d o_carry=%0d, expected o_data=%0d o_carry=%0d",
                         e.name, o_data, o_carry, e.d, e.c);
            end
        end
    end

    task automatic push(input string n, input logic [5:0] d, input logic c);
        exp_t e;
        e.name = n;
        e.d    = d;
        e.c    = c;
        q.push_back(e);
    endtask

    task automatic model_edge();
        logic [6:0] a;
        logic [6:0] s;
        a = '0;
        case (i_sel)
            2'b00: a = {4'b0, i_data1};
            2'b01: a = {4'b0, i_data2};
            2'b10: a = {4'b0, i_data1} + {4'b0, i_data2};
            default: a = '0;
        endcase
        if (i_sel == 2'b11) begin
            mc = 1'b0;
        end else begin
            s  = {1'b0, md} + a;
            md = s[5:0];
            mc = s[6];
        end
    endtask

    task automatic run(input logic [1:0] s, input logic [2:0] a,
                       input logic [2:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            i_sel   = s;
            i_data1 = a;
            i_data2 = b;
            @(posedge clk);
            #1;
            model_edge();
            push("edge", md, mc);
        end
    endtask

    task automatic release_rst();
        @(posedge clk);
        #2;
        i_rst_n = 1'b1;
    endtask

    task automatic assert_rst();
        @(posedge clk);
        #2;
        i_rst_n = 1'b0;
        #1;
        md = '0;
        mc = 1'b0;
        push("async_rst", 6'd0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            push("rst_hold", 6'd0, 1'b0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        md      = '0;
        mc      = 1'b0;
        i_rst_n = 1'b1;
        i_data1 = 3'd1;
        i_data2 = 3'd2;
        i_sel   = 2'b00;
        #1;
        i_rst_n = 1'b0;
        #1;
        push("reset", 6'd0, 1'b0);

        release_rst();
        run(2'b00, 3'd1, 3'd2, 20);
        push("add_d1", 6'd20, 1'b0);

        assert_rst();
        release_rst();
        run(2'b01, 3'd1, 3'd2, 5);
        push("add_d2", 6'd10, 1'b0);
        for (int i = 0; i < 10; i++)
            run(2'b11, 3'($urandom_range(7)), 3'($urandom_range(7)), 1);
        push("hold", 6'd10, 1'b0);
        run(2'b10, 3'd1, 3'd2, 11);
        push("add_sum", 6'd43, 1'b0);

        assert_rst();
        release_rst();
        run(2'b10, 3'd7, 3'd7, 4);
        push("wrap_4", 6'd56, 1'b0);
        run(2'b10, 3'd7, 3'd7, 1);
        push("wrap_5", 6'd6, 1'b1);
        run(2'b10, 3'd7, 3'd7, 1);
        push("wrap_6", 6'd20, 1'b0);

        run(2'b00, 3'd7, 3'd0, 6);
        push("to_62", 6'd62, 1'b0);
        run(2'b01, 3'd5, 3'd1, 1);
        push("to_63", 6'd63, 1'b0);
        run(2'b00, 3'd1, 3'd6, 1);
        push("63_plus_1", 6'd0, 1'b1);
        run(2'b11, 3'd3, 3'd4, 1);
        push("hold_clr_c", 6'd0, 1'b0);

        run(2'b00, 3'd7, 3'd0, 9);
        push("to_63b", 6'd63, 1'b0);
        run(2'b10, 3'd7, 3'd7, 1);
        push("63_plus_14", 6'd13, 1'b1);
        run(2'b00, 3'd0, 3'd5, 2);
        push("zero_op", 6'd13, 1'b0);

        run(2'b01, 3'd0, 3'd6, 3);
        push("pre_rst", 6'd31, 1'b0);
        assert_rst();
        release_rst();
        run(2'b00, 3'd3, 3'd0, 1);
        push("after_rst", 6'd3, 1'b0);

        @(negedge clk);
        @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending, expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
